chacha_round_seq: RTL and testbench



---
 rtl/chacha_round_seq_if.sv | 33 +++
 rtl/chacha_round_seq.sv | 115 +++++++++++
 tb/tb_chacha_round_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_round_seq_if.sv
// Control bundle between the ChaCha round sequencer and the quarter-round lane array.
// The master side is the sequencer. The slave side is the lanes plus the block reader.
interface chacha_round_seq_if;
  localparam int unsigned STEP_W  = 2;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned ROUND_W = 6;

  logic               start;
  logic               ack;
  logic               busy;
  logic               block_ready;
  logic               clear;
  logic               calc;
  logic [STEP_W-1:0]  step;
  logic               shift;
  logic               shift_dir;
  logic [SHIFT_W-1:0] shift_ctr;
  logic               add_back;
  logic               inc_ctr;
  logic [ROUND_W-1:0] round;

  modport master (
    input  start, ack,
    output busy, block_ready, clear, calc, step, shift, shift_dir,
           shift_ctr, add_back, inc_ctr, round
  );

  modport slave (
    output start, ack,
    input  busy, block_ready, clear, calc, step, shift, shift_dir,
           shift_ctr, add_back, inc_ctr, round
  );
endinterface

// File: rtl/chacha_round_seq.sv
// Sequences one ChaCha block through the lanes: clear, ROUNDS x (4 calc + 32 shift), add-back,
// handshake with the reader, then counter increment. All outputs are flops.
module chacha_round_seq #(
  parameter int unsigned ROUNDS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  chacha_round_seq_if.master  bus
);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
  localparam logic [1:0] LAST_STEP  = 2'd3;
  localparam logic [4:0] LAST_SHIFT = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CALC, S_SHIFT, S_ADD, S_READY, S_INC
  } state_t;

  state_t state;

  // Each branch loads the output flops with the values of the state being entered,
  // so every output is a pure function of registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      bus.busy        <= 1'b0;
      bus.block_ready <= 1'b0;
      bus.clear       <= 1'b0;
      bus.calc        <= 1'b0;
      bus.step        <= '0;
      bus.shift       <= 1'b0;
      bus.shift_dir   <= 1'b0;
      bus.shift_ctr   <= '0;
      bus.add_back    <= 1'b0;
      bus.inc_ctr     <= 1'b0;
      bus.round       <= '0;
    end else begin
      bus.clear     <= 1'b0;
      bus.calc      <= 1'b0;
      bus.step      <= '0;
      bus.shift     <= 1'b0;
      bus.shift_dir <= 1'b0;
      bus.shift_ctr <= '0;
      bus.add_back  <= 1'b0;
      bus.inc_ctr   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_CLEAR;
            bus.busy  <= 1'b1;
            bus.clear <= 1'b1;
            bus.round <= '0;
          end
        end

        S_CLEAR: begin
          state    <= S_CALC;
          bus.calc <= 1'b1;
        end

        S_CALC: begin
          if (bus.step == LAST_STEP) begin
            state         <= S_SHIFT;
            bus.shift     <= 1'b1;
            bus.shift_dir <= bus.round[0];
          end else begin
            bus.calc <= 1'b1;
            bus.step <= bus.step + 2'd1;
          end
        end

        S_SHIFT: begin
          if (bus.shift_ctr == LAST_SHIFT) begin
            if (bus.round == LAST_ROUND) begin
              state        <= S_ADD;
              bus.add_back <= 1'b1;
            end else begin
              state     <= S_CALC;
              bus.calc  <= 1'b1;
              bus.round <= bus.round + 6'd1;
            end
          end else begin
            bus.shift     <= 1'b1;
            bus.shift_dir <= bus.shift_dir;
            bus.shift_ctr <= bus.shift_ctr + 5'd1;
          end
        end

        S_ADD: begin
          state           <= S_READY;
          bus.block_ready <= 1'b1;
        end

        S_READY: begin
          if (bus.ack) begin
            state           <= S_INC;
            bus.block_ready <= 1'b0;
            bus.inc_ctr     <= 1'b1;
          end
        end

        S_INC: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state           <= S_IDLE;
          bus.busy        <= 1'b0;
          bus.block_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_round_seq.sv
// Directed bench for chacha_round_seq: ROUNDS=20 schedule, handshake, ignored inputs and resets,
// plus a ROUNDS=2 instance run back-to-back with start and ack held high.
module tb_chacha_round_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  chacha_round_seq_if i20();
  chacha_round_seq_if i2();

  chacha_round_seq #(.ROUNDS(20)) dut20 (.clk(clk), .rst_n(rst_n),  .bus(i20.master));
  chacha_round_seq #(.ROUNDS(2))  dut2  (.clk(clk), .rst_n(rst2_n), .bus(i2.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, block_ready, clear, calc, step, shift, shift_dir, shift_ctr, add_back, inc_ctr, round}
  function automatic logic [20:0] snap20();
    return {i20.busy, i20.block_ready, i20.clear, i20.calc, i20.step, i20.shift,
            i20.shift_dir, i20.shift_ctr, i20.add_back, i20.inc_ctr, i20.round};
  endfunction

  task automatic test_reset();
    logic [20:0] v;
    i20.start = 1'b0; i20.ack = 1'b0;
    i2.start  = 1'b0; i2.ack  = 1'b0;
    rst_n = 1'b0; rst2_n = 1'b0;
    #3;
    v = snap20();
    n_checks++;
    if (v !== 21'd0) begin n_fail++; $display("FAIL reset_values got %h want 0", v); end
    tick(); tick();
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;
    tick();
    n_checks++;
    if (i20.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", i20.busy); end
    // Mid-cycle asynchronous reset while in CALC
    i20.start = 1'b1;
    tick();
    i20.start = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (i20.calc !== 1'b1 || i20.step !== 2'd2 || i20.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_calc got calc=%b step=%0d busy=%b want 1,2,1", i20.calc, i20.step, i20.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    v = snap20();
    n_checks++;
    if (v !== 21'd0) begin n_fail++; $display("FAIL reset_async_drop got %h want 0", v); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_checks++;
    if (i20.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b want 0", i20.busy); end
  endtask

  task automatic test_single_block();
    logic [20:0] v, e;
    logic eb, er, ec, ecalc, esh, edir, eadd, einc;
    logic [1:0] est;
    logic [4:0] ectr;
    logic [5:0] ernd;
    int k, r, o, groups, strobes;
    groups = 0; strobes = 0;
    i20.ack = 1'b1;
    i20.start = 1'b1;
    for (int n = 1; n <= 725; n++) begin
      tick();
      if (n == 1) i20.start = 1'b0;
      eb = 1'b1; er = 1'b0; ec = 1'b0; ecalc = 1'b0; esh = 1'b0; edir = 1'b0;
      eadd = 1'b0; einc = 1'b0; est = 2'd0; ectr = 5'd0; ernd = 6'd19;
      if (n == 1) begin
        ec = 1'b1; ernd = 6'd0;
      end else if (n <= 721) begin
        k = n - 2; r = k / 36; o = k % 36;
        ernd = 6'(r);
        if (o < 4) begin ecalc = 1'b1; est = 2'(o); end
        else begin esh = 1'b1; ectr = 5'(o - 4); edir = ((r % 2) == 1); end
      end else if (n == 722) eadd = 1'b1;
      else if (n == 723) er = 1'b1;
      else if (n == 724) einc = 1'b1;
      else eb = 1'b0;
      e = {eb, er, ec, ecalc, est, esh, edir, ectr, eadd, einc, ernd};
      v = snap20();
      n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL single_block cycle %0d got %h want %h", n, v, e); end
      if (i20.calc === 1'b1 && i20.step === 2'd0) groups++;
      if (i20.calc === 1'b1 || i20.shift === 1'b1) strobes++;
    end
    n_checks++;
    if (groups != 20) begin n_fail++; $display("FAIL single_calc_groups got %0d want 20", groups); end
    n_checks++;
    if (strobes != 720) begin n_fail++; $display("FAIL single_strobe_cycles got %0d want 720", strobes); end
    i20.ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    int guard, incs;
    guard = 0; incs = 0;
    i20.ack = 1'b0;
    i20.start = 1'b1;
    tick();
    i20.start = 1'b0;
    while (i20.block_ready !== 1'b1 && guard < 800) begin tick(); guard++; end
    n_checks++;
    if (guard != 722) begin n_fail++; $display("FAIL delayed_ready_latency got %0d want 722", guard); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (i20.block_ready !== 1'b1 ||
          {i20.clear, i20.calc, i20.shift, i20.add_back, i20.inc_ctr} !== 5'b0) begin
        n_fail++;
        $display("FAIL delayed_hold cycle %0d got ready=%b strobes=%b want 1,00000", i, i20.block_ready,
                 {i20.clear, i20.calc, i20.shift, i20.add_back, i20.inc_ctr});
      end
    end
    i20.ack = 1'b1;
    tick();
    i20.ack = 1'b0;
    n_checks++;
    if (i20.inc_ctr !== 1'b1 || i20.block_ready !== 1'b0) begin
      n_fail++; $display("FAIL delayed_inc got inc=%b ready=%b want 1,0", i20.inc_ctr, i20.block_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i20.inc_ctr === 1'b1) incs++;
    end
    n_checks++;
    if (incs != 0 || i20.busy !== 1'b0) begin
      n_fail++; $display("FAIL delayed_single_inc got extra=%0d busy=%b want 0,0", incs, i20.busy);
    end
  endtask

  task automatic test_ignored_inputs();
    int calcs, shifts, incs;
    calcs = 0; shifts = 0; incs = 0;
    i20.ack = 1'b0;
    i20.start = 1'b1;
    tick();
    i20.start = 1'b0;
    for (int n = 2; n <= 723; n++) begin
      if (n - 1 == 9)  i20.start = 1'b1;
      if (n - 1 == 40) i20.ack   = 1'b1;
      tick();
      i20.start = 1'b0;
      i20.ack   = 1'b0;
      if (i20.calc === 1'b1)    calcs++;
      if (i20.shift === 1'b1)   shifts++;
      if (i20.inc_ctr === 1'b1) incs++;
      if (n == 10) begin
        n_checks++;
        if (i20.shift !== 1'b1 || i20.shift_ctr !== 5'd4) begin
          n_fail++; $display("FAIL ignored_start_shift got shift=%b ctr=%0d want 1,4", i20.shift, i20.shift_ctr);
        end
      end
      if (n == 41) begin
        n_checks++;
        if (i20.calc !== 1'b1 || i20.step !== 2'd3 || i20.round !== 6'd1) begin
          n_fail++; $display("FAIL ignored_ack_calc got calc=%b step=%0d round=%0d want 1,3,1", i20.calc, i20.step, i20.round);
        end
      end
      if (n == 722) begin
        n_checks++;
        if (i20.add_back !== 1'b1) begin n_fail++; $display("FAIL ignored_add got %b want 1", i20.add_back); end
      end
    end
    n_checks++;
    if (i20.block_ready !== 1'b1) begin n_fail++; $display("FAIL ignored_ready got %b want 1", i20.block_ready); end
    n_checks++;
    if (calcs != 80 || shifts != 640 || incs != 0) begin
      n_fail++; $display("FAIL ignored_counts got calc=%0d shift=%0d inc=%0d want 80,640,0", calcs, shifts, incs);
    end
    i20.ack = 1'b1;
    tick();
    i20.ack = 1'b0;
    tick();
    incs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i20.clear === 1'b1 || i20.busy === 1'b1 || i20.inc_ctr === 1'b1) incs++;
    end
    n_checks++;
    if (incs != 0) begin n_fail++; $display("FAIL ignored_no_extra_block got %0d active cycles want 0", incs); end
  endtask

  task automatic test_reset_mid_shift();
    int guard;
    logic [20:0] v;
    guard = 0;
    i20.ack = 1'b0;
    i20.start = 1'b1;
    tick();
    i20.start = 1'b0;
    while (!(i20.shift === 1'b1 && i20.round === 6'd7 && i20.shift_ctr === 5'd13) && guard < 1000) begin
      tick(); guard++;
    end
    n_checks++;
    if (guard != 270) begin n_fail++; $display("FAIL midshift_reach got %0d want 270", guard); end
    #2 rst_n = 1'b0;
    #1;
    v = snap20();
    n_checks++;
    if (v !== 21'd0) begin n_fail++; $display("FAIL midshift_drop got %h want 0", v); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    v = snap20();
    n_checks++;
    if (v !== 21'd0) begin n_fail++; $display("FAIL midshift_idle got %h want 0", v); end
    i20.start = 1'b1;
    tick();
    i20.start = 1'b0;
    n_checks++;
    if (i20.clear !== 1'b1 || i20.round !== 6'd0 || i20.busy !== 1'b1) begin
      n_fail++; $display("FAIL midshift_restart got clear=%b round=%0d busy=%b want 1,0,1", i20.clear, i20.round, i20.busy);
    end
    tick();
    n_checks++;
    if (i20.calc !== 1'b1 || i20.step !== 2'd0 || i20.round !== 6'd0) begin
      n_fail++; $display("FAIL midshift_calc0 got calc=%b step=%0d round=%0d want 1,0,0", i20.calc, i20.step, i20.round);
    end
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int clr_q[$];
    int inc_q[$];
    int first_add, first_ready;
    first_add = 0; first_ready = 0;
    i2.start = 1'b1;
    i2.ack   = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      tick();
      if (i2.clear === 1'b1) clr_q.push_back(n);
      if (i2.inc_ctr === 1'b1) inc_q.push_back(n);
      if (i2.add_back === 1'b1 && first_add == 0) first_add = n;
      if (i2.block_ready === 1'b1 && first_ready == 0) first_ready = n;
    end
    i2.start = 1'b0;
    i2.ack   = 1'b0;
    n_checks++;
    if (first_add != 74) begin n_fail++; $display("FAIL r2_add got %0d want 74", first_add); end
    n_checks++;
    if (first_ready != 75) begin n_fail++; $display("FAIL r2_ready got %0d want 75", first_ready); end
    n_checks++;
    if (clr_q.size() != 3 || inc_q.size() != 2) begin
      n_fail++; $display("FAIL r2_counts got clears=%0d incs=%0d want 3,2", clr_q.size(), inc_q.size());
    end else begin
      n_checks++;
      if (clr_q[0] != 1 || clr_q[1] != 78 || clr_q[2] != 155) begin
        n_fail++; $display("FAIL r2_clear_cycles got %0d,%0d,%0d want 1,78,155", clr_q[0], clr_q[1], clr_q[2]);
      end
      n_checks++;
      if (inc_q[0] + 2 != clr_q[1] || inc_q[1] + 2 != clr_q[2]) begin
        n_fail++; $display("FAIL r2_inc_lead got inc=%0d,%0d clear=%0d,%0d want lead 2", inc_q[0], inc_q[1], clr_q[1], clr_q[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_delayed_ack();
    test_ignored_inputs();
    test_reset_mid_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
